// File: rtl/arb_pkg.sv
// Shared constants and types for the arbiter request queue.
// Default client count, counter width and the pending-count type.
package arb_pkg;

    localparam int CLIENTS_DEF   = 32;
    localparam int CNT_WIDTH_DEF = 4;

    typedef logic [CNT_WIDTH_DEF-1:0] pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/arb_request_queue_if.sv
// Request/grant bundle between clients, the queue and rr_arbiter.
// master: drives pulses, grants, flags_clear; slave: the queue.
interface arb_request_queue_if
    import arb_pkg::*;
#(
    parameter int CLIENTS = CLIENTS_DEF
);

    logic [CLIENTS-1:0] req_pulse;
    logic [CLIENTS-1:0] grant;
    logic               flags_clear;
    logic [CLIENTS-1:0] request;
    logic               pending_any;
    logic [CLIENTS-1:0] overflow;
    logic               spurious_grant;

    modport master (
        output req_pulse,
        output grant,
        output flags_clear,
        input  request,
        input  pending_any,
        input  overflow,
        input  spurious_grant
    );

    modport slave (
        input  req_pulse,
        input  grant,
        input  flags_clear,
        output request,
        output pending_any,
        output overflow,
        output spurious_grant
    );

endinterface

// File: rtl/arb_req_counter.sv
// Per-client saturating pending counter with sticky overflow flag.
// Ports: pulse_i/grant_i/clear_i in; active_o, overflow_o, spur_o out.
module arb_req_counter
    import arb_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse_i,
    input  logic grant_i,
    input  logic clear_i,
    output logic active_o,
    output logic overflow_o,
    output logic spur_o
);

    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 g;

    // A grant only counts when something is pending; otherwise it is spurious.
    assign g      = grant_i && (cnt_q != '0);
    assign spur_o = grant_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = clear_i ? 1'b0 : ovf_q;
        if (pulse_i && !g) begin
            if (cnt_q != MAX) cnt_d = cnt_q + ONE;
            else              ovf_d = 1'b1;
        end else if (!pulse_i && g) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign active_o   = (cnt_q != '0);
    assign overflow_o = ovf_q;

endmodule

// File: rtl/arb_request_queue.sv
// Turns request pulses into level requests for rr_arbiter.
// Ports: clock, reset (async low), bus (slave side of the queue bundle).
module arb_request_queue
    import arb_pkg::*;
#(
    parameter int CLIENTS   = CLIENTS_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    arb_request_queue_if.slave   bus
);

    localparam logic [CLIENTS-1:0] ONE = 1;

    logic [CLIENTS-1:0] active;
    logic [CLIENTS-1:0] ovf;
    logic [CLIENTS-1:0] spur_det;
    logic               multi_hot;
    logic               spur_q, spur_d;

    for (genvar i = 0; i < CLIENTS; i++) begin : g_cnt
        arb_req_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clock      (clock),
            .reset      (reset),
            .pulse_i    (bus.req_pulse[i]),
            .grant_i    (bus.grant[i]),
            .clear_i    (bus.flags_clear),
            .active_o   (active[i]),
            .overflow_o (ovf[i]),
            .spur_o     (spur_det[i])
        );
    end

    // More than one bit set in the grant vector.
    assign multi_hot = |(bus.grant & (bus.grant - ONE));

    // New events override a same-cycle clear.
    always_comb begin
        spur_d = bus.flags_clear ? 1'b0 : spur_q;
        if ((|spur_det) || multi_hot) spur_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) spur_q <= 1'b0;
        else        spur_q <= spur_d;
    end

    assign bus.request        = active;
    assign bus.pending_any    = |active;
    assign bus.overflow       = ovf;
    assign bus.spurious_grant = spur_q;

endmodule

// File: tb/tb_arb_request_queue.sv
// Self-checking bench for arb_request_queue.
// Vector table, corner sequences and randomized model comparison.
module tb_arb_request_queue;

    localparam int N   = 32;
    localparam int MAX = 15;

    logic clock;
    logic reset;

    arb_request_queue_if #(.CLIENTS(N)) bus ();

    arb_request_queue #(
        .CLIENTS   (N),
        .CNT_WIDTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int         m_cnt [N];
    logic [N-1:0] m_ovf;
    logic         m_spur;

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic         c;
        logic [N-1:0] er;
        logic [N-1:0] eo;
        logic         es;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ovf  = '0;
        m_spur = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g,
                              input logic c);
        bit gi;
        if (c) begin
            m_ovf  = '0;
            m_spur = 1'b0;
        end
        if ($countones(g) > 1) m_spur = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (g[i] && m_cnt[i] == 0) m_spur = 1'b1;
            gi = g[i] && m_cnt[i] > 0;
            if (p[i] && !gi) begin
                if (m_cnt[i] < MAX) m_cnt[i]++;
                else                m_ovf[i] = 1'b1;
            end else if (!p[i] && gi) begin
                m_cnt[i]--;
            end
        end
    endtask

    function automatic logic [N-1:0] model_req();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    task automatic step(input logic [N-1:0] p, input logic [N-1:0] g,
                        input logic c);
        bus.req_pulse   = p;
        bus.grant       = g;
        bus.flags_clear = c;
        @(posedge clock);
        model_step(p, g, c);
        #1;
        bus.req_pulse   = '0;
        bus.grant       = '0;
        bus.flags_clear = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".request"}, bus.request, model_req());
        chk({tag, ".pending_any"}, N'(bus.pending_any), N'(model_req() != '0));
        chk({tag, ".overflow"}, bus.overflow, m_ovf);
        chk({tag, ".spurious"}, N'(bus.spurious_grant), N'(m_spur));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_vec(input int k, input logic [N-1:0] p,
                           input logic [N-1:0] g, input logic c,
                           input logic [N-1:0] er, input logic [N-1:0] eo,
                           input logic es);
        vt[k].p  = p;
        vt[k].g  = g;
        vt[k].c  = c;
        vt[k].er = er;
        vt[k].eo = eo;
        vt[k].es = es;
    endtask

    initial begin
        logic [N-1:0] b0, b2, b4, b5, b7, b9, z;
        logic [N-1:0] rp, rg;
        int idx;
        b0 = N'(1) << 0;
        b2 = N'(1) << 2;
        b4 = N'(1) << 4;
        b5 = N'(1) << 5;
        b7 = N'(1) << 7;
        b9 = N'(1) << 9;
        z  = '0;

        bus.req_pulse   = '0;
        bus.grant       = '0;
        bus.flags_clear = 1'b0;
        reset           = 1'b0;
        model_reset();
        #1;

        // Reset held with all pulses active.
        bus.req_pulse = '1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk("rst.request", bus.request, z);
            chk("rst.pending", N'(bus.pending_any), z);
            chk("rst.overflow", bus.overflow, z);
            chk("rst.spurious", N'(bus.spurious_grant), z);
        end
        bus.req_pulse = '0;
        reset = 1'b1;
        step(b2, z, 1'b0);
        chk("post_rst.request", bus.request, b2);
        do_reset();

        // Vector table: lifecycle, spurious/clear, accumulation, multi-hot.
        set_vec(0,  b4, z,  0, b4, z, 0);
        set_vec(1,  z,  z,  0, b4, z, 0);
        set_vec(2,  z,  z,  0, b4, z, 0);
        set_vec(3,  z,  z,  0, b4, z, 0);
        set_vec(4,  z,  b4, 0, z,  z, 0);
        set_vec(5,  z,  b9, 0, z,  z, 1);
        set_vec(6,  z,  b9, 1, z,  z, 1);
        set_vec(7,  z,  z,  1, z,  z, 0);
        set_vec(8,  b7, z,  0, b7, z, 0);
        set_vec(9,  b7, z,  0, b7, z, 0);
        set_vec(10, b7, z,  0, b7, z, 0);
        set_vec(11, z,  b7, 0, b7, z, 0);
        set_vec(12, z,  b7, 0, b7, z, 0);
        set_vec(13, z,  b7, 0, z,  z, 0);
        set_vec(14, z,  (N'(1) << 1) | (N'(1) << 3), 0, z, z, 1);
        set_vec(15, z,  z,  1, z,  z, 0);
        set_vec(16, b5, b5, 0, b5, z, 1);
        set_vec(17, z,  b5, 1, z,  z, 0);
        for (int k = 0; k < 18; k++) begin
            step(vt[k].p, vt[k].g, vt[k].c);
            chk($sformatf("vec%0d.request", k), bus.request, vt[k].er);
            chk($sformatf("vec%0d.pending", k), N'(bus.pending_any),
                N'(vt[k].er != '0));
            chk($sformatf("vec%0d.overflow", k), bus.overflow, vt[k].eo);
            chk($sformatf("vec%0d.spurious", k), N'(bus.spurious_grant),
                N'(vt[k].es));
        end

        // Saturation on client 0.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            step(b0, z, 1'b0);
            chk($sformatf("sat%0d.overflow", k), bus.overflow, z);
        end
        step(b0, z, 1'b0);
        chk("sat16.overflow", bus.overflow, b0);
        chk("sat16.request", bus.request, b0);
        step(z, z, 1'b1);
        chk("sat.clear", bus.overflow, z);
        step(b0, b0, 1'b0);
        chk("sat.pg.overflow", bus.overflow, z);
        chk("sat.pg.request", bus.request, b0);
        for (int k = 1; k <= 14; k++) step(z, b0, 1'b0);
        chk("sat.drain14", bus.request, b0);
        step(z, b0, 1'b0);
        chk("sat.drain15", bus.request, z);
        chk("sat.spurious", N'(bus.spurious_grant), z);

        // Asynchronous reset mid-operation.
        step(b4 | b9, z, 1'b0);
        step(b4, z, 1'b0);
        chk("mid.request", bus.request, b4 | b9);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid.async_drop", bus.request, z);
        chk("mid.async_pending", N'(bus.pending_any), z);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            rp = $urandom & $urandom & $urandom;
            rg = '0;
            idx = $urandom_range(N - 1, 0);
            case ($urandom_range(9, 0))
                0: rg = '0;
                1: rg = N'(1) << idx;
                2: rg = $urandom & $urandom;
                default: begin
                    for (int j = 0; j < N; j++) begin
                        if (rg == '0 && m_cnt[(idx + j) % N] != 0)
                            rg = N'(1) << ((idx + j) % N);
                    end
                end
            endcase
            step(rp, rg, ($urandom_range(19, 0) == 0));
            chk_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_request_queue.md
# arb_request_queue

Upstream request-conditioning stage for the round-robin arbiter `rr_arbiter`. It converts single-cycle request pulses from each client into per-client saturating pending counts, and drives the arbiter's level `request` vector from those counts. Each pending count is decremented by the arbiter's returned `grant`. By construction, a request stays asserted until it is granted, so the arbiter's request-hold assumption holds structurally.

## Interface
Parameters:
- CLIENTS, 32, number of clients; must match `rr_arbiter` CLIENTS.
- CNT_WIDTH, 4, width of each pending counter; maximum pending per client is 2**CNT_WIDTH-1.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; asserting it clears all state immediately, and release is synchronised externally.
- req_pulse  input  CLIENTS  one-cycle request pulse per client; multiple bits may be high in one cycle.
- grant  input  CLIENTS  grant vector from `rr_arbiter`; one-hot or zero.
- request  output  CLIENTS  to `rr_arbiter`; bit i = (count[i] != 0).
- pending_any  output  1  OR of `request`.
- overflow  output  CLIENTS  sticky; bit i set when a pulse for client i is dropped at saturation.
- spurious_grant  output  1  sticky; set when a grant arrives for a client whose count is 0.
- flags_clear  input  1  synchronous clear of `overflow` and `spurious_grant`.

## Operation
- Each client has an independent counter count[i] of CNT_WIDTH bits. Per-cycle update for client i:
  - p = req_pulse[i], g = grant[i] && count[i] != 0.
  - p && !g: increment if count < MAX; else hold and set overflow[i].
  - !p && g: decrement.
  - p && g: hold. This is a net-zero change, and no overflow is flagged even at MAX.
  - neither: hold.
- grant[i] while count[i] == 0: no decrement (no underflow) and spurious_grant is set. A same-cycle pulse still increments the count.
- A multi-hot grant is treated bitwise and also sets spurious_grant.
- flags_clear in the same cycle as a new flag event: the set wins.
- `request` and `pending_any` are combinational from registered counts only. There is no combinational path from any input to any output.

## Timing
- Reset values: all counts 0; `request` = 0; `pending_any` = 0; `overflow` = 0; `spurious_grant` = 0.
- Pulse-to-request latency: a pulse sampled at edge t makes `request` high after edge t (visible cycle t+1).
- Grant-to-drop latency: a grant sampled at edge t with count 1 drops `request` after edge t.
- Back-to-back pulses: a pulse every cycle with no grants reaches MAX after MAX edges. The next pulse sets overflow.
- Reset mid-operation: outstanding counts are discarded, and `request` falls asynchronously with reset assertion.
- Stall: this block does not observe `stall`. When stalled the arbiter issues no grants, so counts only grow or saturate.

## Structure
- Shared package `arb_pkg`:
  - CLIENTS default constant.
  - CNT_WIDTH default constant.
  - typedef `pend_cnt_t` (logic [CNT_WIDTH-1:0]).
  - localparam PEND_MAX.
- Sub-module `arb_req_counter`:
  - One per client, generated CLIENTS times.
  - Holds the saturating up/down counter, the overflow flag and the local spurious detect.
  - The top level ORs the local spurious bits into `spurious_grant` and forms `request` / `pending_any`.
- Formal bench shares these port names with the `rr_arbiter` bench, so the two blocks can be bound together for end-to-end liveness checks.

## Test plan
- Reset with pulses active: hold reset low, drive req_pulse = all ones → `request` = 0 and every count 0 throughout; after release, one pulse on bit 2 → request[2] = 1 next cycle.
- Single request lifecycle: pulse bit 4 at cycle 1, grant[4] at cycle 5 → request[4] high on cycles 2–5, low from cycle 6; overflow = 0, spurious_grant = 0.
- Accumulation: 3 pulses on bit 7, then 3 grants → request[7] stays high through the 3rd grant edge, then falls; no flags set.
- Saturation (CNT_WIDTH = 4): 16 consecutive pulses on bit 0 → count 15, overflow[0] = 1 after the 16th pulse; a pulse+grant pair at count 15 → count stays 15 and no additional overflow event.
- Spurious grant and clear priority: grant[9] with count 0 → spurious_grant = 1, count stays 0; then flags_clear together with a new spurious grant → spurious_grant remains 1; flags_clear alone → 0.
- Integration with `rr_arbiter` (stall low): pulse on bit 4 → grant[4] within 32 cycles and request[4] never falls before that grant.
